// File: rtl/seq_pkg.sv
// Shared instruction-format constants and sequencer state encoding.
// Imported by the sequencer and intended for the player's note decode.
package seq_pkg;

  localparam logic [3:0] OP_END = 4'b0000;
  localparam logic [3:0] OP_BPM = 4'b0001;
  localparam int NOTE_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FIN    = 3'd5
  } seq_state_t;

  function automatic logic [3:0] ins_opcode(input logic [15:0] ins);
    return ins[15:12];
  endfunction

  function automatic logic [11:0] ins_bpm(input logic [15:0] ins);
    return ins[11:0];
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO; a pop frees its slot in the same cycle,
// so push and pop together are legal even when full.
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ins_sequencer.sv
// Fetches program words from SRAM starting at address 0, executes BPM/END
// internally and buffers note words for the player behind a small FIFO.
module ins_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int SRAM_LAT    = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int BPM_DEFAULT = 96
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [15:0]       SRAM_D,
  output logic              NOTE_VALID,
  output logic [15:0]       NOTE_INS,
  input  logic              NOTE_READY,
  output logic [11:0]       BPM,
  output logic              BPM_UPD,
  output logic              BUSY,
  output logic              DONE,
  output seq_state_t        DBG_STATE
);

  // Handshake: a note transfers on any rising CLK where NOTE_VALID and
  // NOTE_READY are both high; NOTE_INS holds steady while VALID && !READY.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [11:0] BPM_RST = 12'(BPM_DEFAULT);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [15:0]       ins_q, ins_d;
  logic [11:0]       bpm_q, bpm_d;
  logic              upd_q, upd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_push;
  logic              fifo_clr;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign fifo_pop = NOTE_READY;

  note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .data_i  (ins_q),
    .pop_i   (fifo_pop),
    .data_o  (NOTE_INS),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ins_d     = ins_q;
    bpm_d     = bpm_q;
    upd_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    fifo_push = 1'b0;
    fifo_clr  = 1'b0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          fifo_clr = 1'b1;
          pc_d     = '0;
          bpm_d    = BPM_RST;
          upd_d    = (bpm_q != BPM_RST);
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Only one fetch is ever in flight, so a free slot now is a free
        // slot when its word reaches DECODE.
        if (fifo_count < CW'(FIFO_DEPTH)) begin
          addr_d  = pc_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LW'(SRAM_LAT - 1)) begin
          ins_d   = SRAM_D;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_ADDR;
        if (ins_q[NOTE_BIT]) begin
          fifo_push = 1'b1;
        end else if (ins_opcode(ins_q) == OP_BPM) begin
          if (ins_bpm(ins_q) != 12'd0 && ins_bpm(ins_q) != bpm_q) begin
            bpm_d = ins_bpm(ins_q);
            upd_d = 1'b1;
          end
        end else if (ins_opcode(ins_q) == OP_END) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ins_q   <= '0;
      bpm_q   <= BPM_RST;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      bpm_q   <= bpm_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SRAM_A     = addr_q;
  assign NOTE_VALID = !fifo_empty;
  assign BPM        = bpm_q;
  assign BPM_UPD    = upd_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign DBG_STATE  = state_q;

  no_push_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
    !(fifo_push && fifo_full && !(fifo_pop && !fifo_empty)));

endmodule
